// File: rtl/mem_unit_if.sv
// Data-memory request bus between the MEM pipeline stage and the data memory.
// The stage drives the master side; the memory drives the slave side.
interface mem_unit_if;
   // Handshake: a request (D_MEM_READ or D_MEM_WRITE) stays high with a stable address,
   // write data and byte enables until the first rising edge at which D_MEM_BUSYWAIT=0.
   // That edge completes the transfer; BUSYWAIT is not sampled in the first request cycle.
   logic        D_MEM_READ;
   logic        D_MEM_WRITE;
   logic [31:0] D_MEM_ADDR;
   logic [31:0] D_MEM_WDATA;
   logic [3:0]  D_MEM_BYTE_EN;
   logic [31:0] D_MEM_RDATA;
   logic        D_MEM_BUSYWAIT;

   modport master (
      output D_MEM_READ, D_MEM_WRITE, D_MEM_ADDR, D_MEM_WDATA, D_MEM_BYTE_EN,
      input  D_MEM_RDATA, D_MEM_BUSYWAIT
   );

   modport slave (
      input  D_MEM_READ, D_MEM_WRITE, D_MEM_ADDR, D_MEM_WDATA, D_MEM_BYTE_EN,
      output D_MEM_RDATA, D_MEM_BUSYWAIT
   );
endinterface

// File: rtl/mem_unit.sv
// MEM pipeline stage: EX/MEM stage register, data-memory handshake FSM,
// store lane formatting and load extension.
module mem_unit #(
   parameter int unsigned ACCESS_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
   input  logic        REG_WRITE_EN_EX,
   input  logic [1:0]  WB_VALUE_SEL_EX,
   input  logic        MEM_READ_EN_EX,
   input  logic        MEM_WRITE_EN_EX,
   input  logic [31:0] PC_EX,
   input  logic [31:0] RESULT_EX,
   input  logic [31:0] REG_DATA_2_EX,
   input  logic [2:0]  FUNC3_EX,
   input  logic [4:0]  REG_WRITE_ADDR_EX,
   mem_unit_if.master  dmem,
   output logic        REG_WRITE_EN_MEM,
   output logic [1:0]  WB_VALUE_SEL_MEM,
   output logic [4:0]  REG_WRITE_ADDR_MEM,
   output logic [31:0] ALU_RES_MEM,
   output logic [31:0] PC_4_MEM,
   output logic [31:0] LOAD_DATA_MEM,
   output logic        MEM_STALL,
   output logic        MISALIGNED,
   output logic        BUS_ERROR,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [31:0] TIMEOUT = 32'(ACCESS_TIMEOUT);

   state_t      state;
   logic [31:0] cnt;

   logic        rwe_q;
   logic [1:0]  wbs_q;
   logic        mr_q;
   logic        mw_q;
   logic [31:0] pc4_q;
   logic [31:0] alu_q;
   logic [31:0] d2_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic [31:0] load_q;
   logic        berr_q;

   logic        is_mem;
   logic        misalign;
   logic        pending;
   logic        req_active;
   logic        advance;
   logic [31:0] st_data;
   logic [3:0]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // A misaligned access never reaches the bus, so it cannot stall the pipe.
   always_comb begin
      is_mem     = mr_q | mw_q;
      misalign   = is_mem & (((f3_q[1:0] == 2'b01) & alu_q[0]) |
                             ((f3_q[1:0] == 2'b10) & (|alu_q[1:0])));
      pending    = is_mem & ~misalign;
      req_active = ((state == IDLE) & pending) | (state == ACCESS);
      advance    = ~req_active;
   end

   always_comb begin
      st_data = d2_q;
      st_be   = 4'b1111;
      case (f3_q[1:0])
         2'b00: begin
            st_data = {4{d2_q[7:0]}};
            st_be   = 4'b0001 << alu_q[1:0];
         end
         2'b01: begin
            st_data = {2{d2_q[15:0]}};
            st_be   = alu_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = d2_q;
            st_be   = 4'b1111;
         end
      endcase
   end

   always_comb begin
      case (alu_q[1:0])
         2'b00:   ld_byte = dmem.D_MEM_RDATA[7:0];
         2'b01:   ld_byte = dmem.D_MEM_RDATA[15:8];
         2'b10:   ld_byte = dmem.D_MEM_RDATA[23:16];
         default: ld_byte = dmem.D_MEM_RDATA[31:24];
      endcase
      ld_half = alu_q[1] ? dmem.D_MEM_RDATA[31:16] : dmem.D_MEM_RDATA[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = dmem.D_MEM_RDATA;
      endcase
   end

   // Read+write staged together is issued as a write only.
   assign dmem.D_MEM_READ    = req_active & mr_q & ~mw_q;
   assign dmem.D_MEM_WRITE   = req_active & mw_q;
   assign dmem.D_MEM_ADDR    = {alu_q[31:2], 2'b00};
   assign dmem.D_MEM_WDATA   = st_data;
   assign dmem.D_MEM_BYTE_EN = (req_active & mw_q) ? st_be : 4'b0000;

   assign REG_WRITE_EN_MEM   = rwe_q & ~misalign & ~berr_q;
   assign WB_VALUE_SEL_MEM   = wbs_q;
   assign REG_WRITE_ADDR_MEM = rd_q;
   assign ALU_RES_MEM        = alu_q;
   assign PC_4_MEM           = pc4_q;
   assign LOAD_DATA_MEM      = load_q;
   assign MEM_STALL          = req_active;
   assign MISALIGNED         = misalign;
   assign BUS_ERROR          = berr_q;
   assign dbg_state          = state;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= 32'd0;
         rwe_q  <= 1'b0;
         wbs_q  <= 2'b00;
         mr_q   <= 1'b0;
         mw_q   <= 1'b0;
         pc4_q  <= 32'd0;
         alu_q  <= 32'd0;
         d2_q   <= 32'd0;
         f3_q   <= 3'd0;
         rd_q   <= 5'd0;
         load_q <= 32'd0;
         berr_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  state <= ACCESS;
                  cnt   <= 32'd0;
               end
            end
            ACCESS: begin
               // Completion wins over a timeout that lands on the same edge.
               if (!dmem.D_MEM_BUSYWAIT) begin
                  if (mr_q & ~mw_q) load_q <= ld_ext;
                  state <= DONE;
               end else if ((TIMEOUT != 32'd0) && ((cnt + 32'd1) == TIMEOUT)) begin
                  berr_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (advance) begin
            berr_q <= 1'b0;
            if (FLUSH) begin
               rwe_q <= 1'b0;
               wbs_q <= 2'b00;
               mr_q  <= 1'b0;
               mw_q  <= 1'b0;
               pc4_q <= 32'd0;
               alu_q <= 32'd0;
               d2_q  <= 32'd0;
               f3_q  <= 3'd0;
               rd_q  <= 5'd0;
            end else begin
               rwe_q <= REG_WRITE_EN_EX;
               wbs_q <= WB_VALUE_SEL_EX;
               mr_q  <= MEM_READ_EN_EX;
               mw_q  <= MEM_WRITE_EN_EX;
               pc4_q <= PC_EX + 32'd4;
               alu_q <= RESULT_EX;
               d2_q  <= REG_DATA_2_EX;
               f3_q  <= FUNC3_EX;
               rd_q  <= REG_WRITE_ADDR_EX;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed and random instructions, a reference model with its own
// memory image, a latency-driven memory responder and a retirement-time scoreboard.
module tb_mem_unit;
  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        REG_WRITE_EN_EX;
  logic [1:0]  WB_VALUE_SEL_EX;
  logic        MEM_READ_EN_EX;
  logic        MEM_WRITE_EN_EX;
  logic [31:0] PC_EX;
  logic [31:0] RESULT_EX;
  logic [31:0] REG_DATA_2_EX;
  logic [2:0]  FUNC3_EX;
  logic [4:0]  REG_WRITE_ADDR_EX;
  logic        REG_WRITE_EN_MEM;
  logic [1:0]  WB_VALUE_SEL_MEM;
  logic [4:0]  REG_WRITE_ADDR_MEM;
  logic [31:0] ALU_RES_MEM;
  logic [31:0] PC_4_MEM;
  logic [31:0] LOAD_DATA_MEM;
  logic        MEM_STALL;
  logic        MISALIGNED;
  logic        BUS_ERROR;
  logic [1:0]  dbg_state;

  mem_unit_if bus ();

  mem_unit #(.ACCESS_TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .REG_WRITE_EN_EX(REG_WRITE_EN_EX), .WB_VALUE_SEL_EX(WB_VALUE_SEL_EX),
    .MEM_READ_EN_EX(MEM_READ_EN_EX), .MEM_WRITE_EN_EX(MEM_WRITE_EN_EX),
    .PC_EX(PC_EX), .RESULT_EX(RESULT_EX), .REG_DATA_2_EX(REG_DATA_2_EX),
    .FUNC3_EX(FUNC3_EX), .REG_WRITE_ADDR_EX(REG_WRITE_ADDR_EX),
    .dmem(bus.master),
    .REG_WRITE_EN_MEM(REG_WRITE_EN_MEM), .WB_VALUE_SEL_MEM(WB_VALUE_SEL_MEM),
    .REG_WRITE_ADDR_MEM(REG_WRITE_ADDR_MEM), .ALU_RES_MEM(ALU_RES_MEM),
    .PC_4_MEM(PC_4_MEM), .LOAD_DATA_MEM(LOAD_DATA_MEM), .MEM_STALL(MEM_STALL),
    .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rwe;
    logic [1:0]  wbs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    logic [7:0]  stall;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_load;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endfunction

  // reference model: plain arithmetic over a word-array memory image
  task automatic model_issue(input logic rwe, input logic [1:0] wbs, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] res, input logic [31:0] d2,
                             input logic [2:0] f3, input logic mr, input logic mw, input logic fl,
                             input int lat, output exp_t e, output logic pend);
    int sz, lane, idx, acc;
    logic [31:0] w, by, hw, v, mask;
    e = '0;
    pend = 1'b0;
    if (!fl) begin
      sz   = int'(f3 % 3'd4);
      lane = int'(res % 32'd4);
      idx  = int'((res / 32'd4) % 32'd64);
      e.mis = (mr || mw) && ((sz == 1 && (res % 32'd2) != 0) || (sz == 2 && lane != 0));
      pend  = (mr || mw) && !e.mis;
      e.wbs = wbs;
      e.rd  = rd;
      e.alu = res;
      e.pc4 = pc + 32'd4;
      if (pend) begin
        acc     = (lat < T) ? lat + 1 : T;
        e.berr  = (lat >= T);
        e.stall = 8'(1 + acc);
        e.addr  = res - (res % 32'd4);
        if (mw) begin
          e.wr_req = 1'b1;
          if (sz == 0) begin
            e.wdata = (d2 % 32'd256) * 32'h0101_0101;
            e.be    = 4'(1 << lane);
          end else if (sz == 1) begin
            e.wdata = (d2 % 32'd65536) * 32'h0001_0001;
            e.be    = (lane >= 2) ? 4'b1100 : 4'b0011;
          end else begin
            e.wdata = d2;
            e.be    = 4'b1111;
          end
          if (!e.berr)
            for (int k = 0; k < 4; k++)
              if (e.be[k]) begin
                mask = 32'hFF << (8 * k);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | (e.wdata & mask);
              end
        end else begin
          e.rd_req = 1'b1;
          if (!e.berr) begin
            w  = ref_mem[idx];
            by = (w >> (8 * lane)) % 32'd256;
            hw = (w >> (16 * (lane / 2))) % 32'd65536;
            case (f3)
              3'd0:    v = (by >= 32'd128) ? by + 32'hFFFF_FF00 : by;
              3'd1:    v = (hw >= 32'd32768) ? hw + 32'hFFFF_0000 : hw;
              3'd4:    v = by;
              3'd5:    v = hw;
              default: v = w;
            endcase
            last_load = v;
          end
        end
      end
      e.rwe = rwe && !e.mis && !e.berr;
    end
    e.ld = last_load;
  endtask

  // driver: present one instruction, wait until the stage accepts it, record expectation
  task automatic issue(input logic rwe, input logic [1:0] wbs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] res, input logic [31:0] d2,
                       input logic [2:0] f3, input logic mr, input logic mw, input logic fl,
                       input int lat);
    exp_t e;
    logic pend;
    bit ok;
    REG_WRITE_EN_EX = rwe; WB_VALUE_SEL_EX = wbs; REG_WRITE_ADDR_EX = rd;
    PC_EX = pc; RESULT_EX = res; REG_DATA_2_EX = d2; FUNC3_EX = f3;
    MEM_READ_EN_EX = mr; MEM_WRITE_EN_EX = mw; FLUSH = fl;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!MEM_STALL) begin ok = 1'b1; break; end
    end
    if (!ok) chk("issue_wait_stall", {31'd0, MEM_STALL}, 32'd0);
    @(posedge CLK);
    #1;
    model_issue(rwe, wbs, rd, pc, res, d2, f3, mr, mw, fl, lat, e, pend);
    exp_q.push_back(e);
    if (pend) lat_q.push_back(lat);
  endtask

  task automatic rand_issue();
    int op;
    logic mr, mw;
    logic [2:0] f3;
    logic [31:0] res;
    op = $urandom_range(0, 9);
    mr = (op >= 3 && op <= 5) || op == 9;
    mw = op >= 6;
    f3  = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
    res = (mr || mw) ? 32'($urandom_range(0, 255)) : $urandom;
    issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
          $urandom, res, $urandom, f3, mr, mw, ($urandom_range(0, 9) == 0),
          $urandom_range(0, 5));
  endtask

  // memory responder: busy for the requested number of ACCESS cycles, writes on completion
  bit          in_prog;
  int          rcnt, rlat;
  logic [5:0]  widx;
  always @(negedge CLK) begin
    if (RESET) begin
      in_prog = 1'b0;
      bus.D_MEM_BUSYWAIT = 1'b0;
      bus.D_MEM_RDATA = 32'd0;
    end else if (bus.D_MEM_READ || bus.D_MEM_WRITE) begin
      widx = bus.D_MEM_ADDR[7:2];
      if (!in_prog) begin
        in_prog = 1'b1;
        rcnt = 0;
        rlat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        bus.D_MEM_BUSYWAIT = 1'($urandom_range(0, 1));
      end else begin
        rcnt++;
        if (rcnt <= rlat) bus.D_MEM_BUSYWAIT = 1'b1;
        else begin
          bus.D_MEM_BUSYWAIT = 1'b0;
          if (bus.D_MEM_WRITE)
            for (int k = 0; k < 4; k++)
              if (bus.D_MEM_BYTE_EN[k]) mem[widx][8*k +: 8] = bus.D_MEM_WDATA[8*k +: 8];
        end
      end
      bus.D_MEM_RDATA = mem[widx];
    end else begin
      in_prog = 1'b0;
      bus.D_MEM_BUSYWAIT = 1'($urandom_range(0, 1));
      bus.D_MEM_RDATA = $urandom;
    end
  end

  // scoreboard monitor: compare each staged instruction on the cycle it retires
  int          stall_seen, req_seen;
  logic        rd_seen, wr_seen;
  logic [31:0] a_seen, wd_seen;
  logic [3:0]  be_seen;
  exp_t        me;

  task automatic mon_clear();
    stall_seen = 0; req_seen = 0; rd_seen = 1'b0; wr_seen = 1'b0;
    a_seen = 32'd0; wd_seen = 32'd0; be_seen = 4'd0;
  endtask

  always @(negedge CLK) begin
    if (RESET) mon_clear();
    else if (MEM_STALL) begin
      stall_seen++;
      if (bus.D_MEM_READ || bus.D_MEM_WRITE) begin
        req_seen++;
        rd_seen = rd_seen | bus.D_MEM_READ;
        wr_seen = wr_seen | bus.D_MEM_WRITE;
        a_seen  = bus.D_MEM_ADDR;
        be_seen = bus.D_MEM_BYTE_EN;
        if (bus.D_MEM_WRITE) wd_seen = bus.D_MEM_WDATA;
      end
    end else begin
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("reg_write_en", {31'd0, REG_WRITE_EN_MEM}, {31'd0, me.rwe});
        chk("wb_sel", {30'd0, WB_VALUE_SEL_MEM}, {30'd0, me.wbs});
        chk("rd_addr", {27'd0, REG_WRITE_ADDR_MEM}, {27'd0, me.rd});
        chk("alu_res", ALU_RES_MEM, me.alu);
        chk("pc_4", PC_4_MEM, me.pc4);
        chk("load_data", LOAD_DATA_MEM, me.ld);
        chk("misaligned", {31'd0, MISALIGNED}, {31'd0, me.mis});
        chk("bus_error", {31'd0, BUS_ERROR}, {31'd0, me.berr});
        chk("stall_cycles", 32'(stall_seen), {24'd0, me.stall});
        chk("req_cycles", 32'(req_seen), {24'd0, me.stall});
        chk("read_req", {31'd0, rd_seen}, {31'd0, me.rd_req});
        chk("write_req", {31'd0, wr_seen}, {31'd0, me.wr_req});
        chk("req_addr", a_seen, me.addr);
        chk("wdata", wd_seen, me.wdata);
        chk("byte_en", {28'd0, be_seen}, {28'd0, me.be});
        chk("retire_req", {31'd0, bus.D_MEM_READ | bus.D_MEM_WRITE}, 32'd0);
        chk("retire_be", {28'd0, bus.D_MEM_BYTE_EN}, 32'd0);
      end
      mon_clear();
    end
  end

  task automatic drive_idle();
    FLUSH = 1'b1; REG_WRITE_EN_EX = 1'b0; WB_VALUE_SEL_EX = 2'b00; MEM_READ_EN_EX = 1'b0;
    MEM_WRITE_EN_EX = 1'b0; PC_EX = 32'd0; RESULT_EX = 32'd0; REG_DATA_2_EX = 32'd0;
    FUNC3_EX = 3'd0; REG_WRITE_ADDR_EX = 5'd0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_stall"}, {31'd0, MEM_STALL}, 32'd0);
    chk({tag, "_read"}, {31'd0, bus.D_MEM_READ}, 32'd0);
    chk({tag, "_write"}, {31'd0, bus.D_MEM_WRITE}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    chk({tag, "_rwe"}, {31'd0, REG_WRITE_EN_MEM}, 32'd0);
    chk({tag, "_alu"}, ALU_RES_MEM, 32'd0);
    chk({tag, "_pc4"}, PC_4_MEM, 32'd0);
    chk({tag, "_load"}, LOAD_DATA_MEM, 32'd0);
    chk({tag, "_berr"}, {31'd0, BUS_ERROR}, 32'd0);
  endtask

  initial begin
    bit drained;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h80FF_0000;
    ref_mem[0] = 32'h80FF_0000;
    last_load = 32'd0;
    drive_idle();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_cleared("reset");
    RESET = 1'b0;

    // directed: ALU with PC wrap, LB sign-extend, SH upper half, misaligned LW, timeout, 0-wait LW
    issue(1'b1, 2'b00, 5'd5, 32'hFFFF_FFFC, 32'h0000_1234, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    issue(1'b1, 2'b01, 5'd6, 32'h0000_1000, 32'h0000_0103, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2);
    issue(1'b0, 2'b00, 5'd0, 32'h0000_1004, 32'h0000_0202, 32'hAAAA_BEEF, 3'd1, 1'b0, 1'b1, 1'b0, 1);
    issue(1'b1, 2'b01, 5'd7, 32'h0000_1008, 32'h0000_0101, 32'd0, 3'd2, 1'b1, 1'b0, 1'b0, 0);
    issue(1'b1, 2'b01, 5'd8, 32'h0000_100C, 32'h0000_0020, 32'd0, 3'd2, 1'b1, 1'b0, 1'b0, 7);
    issue(1'b1, 2'b01, 5'd9, 32'h0000_1010, 32'h0000_0000, 32'd0, 3'd2, 1'b1, 1'b0, 1'b0, 0);

    for (int n = 0; n < 200; n++) rand_issue();

    // reset in the middle of an ACCESS, then a flushed store
    issue(1'b1, 2'b01, 5'd3, 32'h0000_2000, 32'h0000_0040, 32'd0, 3'd2, 1'b1, 1'b0, 1'b0, 9);
    @(negedge CLK);
    @(posedge CLK);
    #2;
    chk("mid_read_req", {31'd0, bus.D_MEM_READ}, 32'd1);
    chk("mid_state", {30'd0, dbg_state}, 32'd1);
    RESET = 1'b1;
    #1;
    check_cleared("mid_reset");
    exp_q.delete();
    lat_q.delete();
    last_load = 32'd0;
    drive_idle();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    issue(1'b1, 2'b00, 5'd4, 32'h0000_3000, 32'h0000_0010, 32'h1234_5678, 3'd2, 1'b0, 1'b1, 1'b1, 0);
    for (int n = 0; n < 20; n++) rand_issue();

    drive_idle();
    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      #1;
      if (exp_q.size() == 0) begin drained = 1'b1; break; end
    end
    if (!drained) chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM stage register and drives the data-memory request/busywait handshake.
- Formats store data and byte enables, and sign/zero-extends load data.
- Feeds the write-back stage and supplies ALU_RES_MEM and REG_WRITE_ADDR_MEM to the execute forwarding unit; raises MEM_STALL to freeze the upstream stages.

Parameters:
- ACCESS_TIMEOUT, 255: max cycles in ACCESS before the request is aborted with BUS_ERROR; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  load a bubble instead of the EX outputs at the next advancing edge.
- REG_WRITE_EN_EX  in  1  register write enable from EX.
- WB_VALUE_SEL_EX  in  2  write-back select: 00 ALU result, 01 memory data, 10 PC+4.
- MEM_READ_EN_EX  in  1  load instruction.
- MEM_WRITE_EN_EX  in  1  store instruction.
- PC_EX  in  32  instruction PC.
- RESULT_EX  in  32  ALU result; the memory address for loads and stores.
- REG_DATA_2_EX  in  32  forwarded store data.
- FUNC3_EX  in  3  access size and sign.
- REG_WRITE_ADDR_EX  in  5  destination register.
- D_MEM_READ  out  1  memory read request.
- D_MEM_WRITE  out  1  memory write request.
- D_MEM_ADDR  out  32  word-aligned address, {ALU_RES_MEM[31:2],2'b00}.
- D_MEM_WDATA  out  32  lane-replicated store data.
- D_MEM_BYTE_EN  out  4  store byte lanes.
- D_MEM_RDATA  in  32  memory read word.
- D_MEM_BUSYWAIT  in  1  high while memory is still servicing the request.
- REG_WRITE_EN_MEM  out  1  staged write enable; forced 0 on misalign or bus error.
- WB_VALUE_SEL_MEM  out  2  staged write-back select.
- REG_WRITE_ADDR_MEM  out  5  staged destination register.
- ALU_RES_MEM  out  32  staged ALU result.
- PC_4_MEM  out  32  staged PC+4.
- LOAD_DATA_MEM  out  32  extended load result.
- MEM_STALL  out  1  stage busy; upstream stages must hold.
- MISALIGNED  out  1  the staged access is misaligned.
- BUS_ERROR  out  1  the staged access timed out.

Behaviour:
- Reset: asynchronous. Every register and output goes to 0, FSM to IDLE. Requests drop in the same instant, including mid-access.
- Stage register advances on a rising edge when MEM_STALL=0.
  - FLUSH=1: loads a bubble (all enables 0, data fields 0).
  - Otherwise: captures the EX inputs; PC_4_MEM = PC_EX+4, modulo 2^32.
- Pending access: staged READ|WRITE, and aligned.
  - Both READ and WRITE staged: treated as a write.
- Alignment:
  - FUNC3[1:0]=01 (half) requires addr[0]=0.
  - FUNC3[1:0]=10 (word) requires addr[1:0]=0.
  - Misaligned access: no request issued, MISALIGNED=1, REG_WRITE_EN_MEM=0, no stall.
- FSM, state IDLE:
  - Pending: request asserted combinationally, MEM_STALL=1, next state ACCESS, timeout counter cleared.
  - Not pending: MEM_STALL=0.
- FSM, state ACCESS:
  - Request held, MEM_STALL=1, counter increments each cycle.
  - Edge with D_MEM_BUSYWAIT=0: LOAD_DATA_MEM is captured (loads only) and the FSM moves to DONE.
  - Counter reaches ACCESS_TIMEOUT (when nonzero): FSM moves to DONE with BUS_ERROR set and REG_WRITE_EN_MEM cleared.
- FSM, state DONE: request low, MEM_STALL=0. The stage advances on this edge; next state IDLE.
- BUS_ERROR and MISALIGNED clear when the stage advances.
- Minimum memory instruction occupancy: 3 cycles (IDLE, ACCESS, DONE). Non-memory instructions: 1 cycle.
- Store formatting (lane = addr[1:0]):
  - SB: WDATA={4{d[7:0]}}, BYTE_EN=0001<<lane.
  - SH: WDATA={2{d[15:0]}}, BYTE_EN = addr[1] ? 1100 : 0011.
  - SW: WDATA=d, BYTE_EN=1111.
  - BYTE_EN is 0000 whenever D_MEM_WRITE=0.
- Load extension:
  - FUNC3 000 LB: selected byte, sign-extended.
  - 001 LH: selected half, sign-extended.
  - 010 LW: full word.
  - 100 LBU: selected byte, zero-extended.
  - 101 LHU: selected half, zero-extended.
  - Other FUNC3 values: treated as LW.
- BUSYWAIT low on the very first ACCESS cycle is legal (single-cycle memory).
- BUSYWAIT is ignored outside ACCESS.

Test Plan:
- ALU instruction, RESULT_EX=0x0000_1234, REG_WRITE_EN_EX=1 -> the next edge shows ALU_RES_MEM=0x1234, REG_WRITE_EN_MEM=1; MEM_STALL stays 0 and there are no requests.
- LB at addr 0x103 with RDATA=0x80FF_0000, BUSYWAIT high for 2 ACCESS cycles -> MEM_STALL high for 4 cycles; LOAD_DATA_MEM=0xFFFF_FF80; D_MEM_ADDR=0x100.
- SH at addr 0x202, d=0xAAAA_BEEF -> WDATA=0xBEEF_BEEF, BYTE_EN=1100, D_MEM_WRITE held until BUSYWAIT low.
- LW at addr 0x101 -> no request, MISALIGNED=1, REG_WRITE_EN_MEM=0, MEM_STALL=0.
- ACCESS_TIMEOUT=4 with BUSYWAIT stuck high -> abort after 4 ACCESS cycles, BUS_ERROR=1, then stage advances.
- RESET asserted mid-ACCESS -> D_MEM_READ drops immediately, all outputs 0, FSM IDLE; FLUSH with a store staged next -> bubble, no write issued.
